// File: rtl/duck_pkg.sv
// Shared types and constants for the light-gun path; the pattern stage imports flash_t from here.
package duck_pkg;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  typedef enum logic [1:0] {IDLE = 2'd0, BLACK = 2'd1, WHITE = 2'd2} flash_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_BLACK, ST_WHITE, ST_EVAL, ST_HOLD
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
module debouncer #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic screen_reset,
  input  logic din,
  output logic level
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // cnt tracks how long the synchronized sample has disagreed with level
  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/zapper_ctrl.sv
// Light-gun shot sequencer: trigger -> black frame -> white frame -> score hit or miss.
module zapper_ctrl
  import duck_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DETECT_MIN      = 64,
  parameter int AMBIENT_MAX     = 16,
  parameter int SHOTS           = 3
) (
  input  logic       clk,
  input  logic       screen_reset,
  input  logic       frame_start,
  input  logic       valid,
  input  logic       trigger_raw,
  input  logic       detect_raw,
  input  logic       new_round,
  output logic [1:0] flash,
  output logic       hit,
  output logic       miss,
  output logic [1:0] shots_left,
  output logic       busy
);
  localparam logic [15:0] DMIN  = 16'(DETECT_MIN);
  localparam logic [15:0] AMAX  = 16'(AMBIENT_MAX);
  localparam logic [1:0]  RLOAD = 2'(SHOTS);

  state_t      state, nxt;
  logic        trig_lvl, trig_q, trig_rise;
  logic        det1, det_s;
  logic [15:0] ambient_cnt, light_cnt;
  logic        arm_go, pass;

  debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_trig_db (
    .clk          (clk),
    .screen_reset (screen_reset),
    .din          (trigger_raw),
    .level        (trig_lvl)
  );

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      det1   <= 1'b0;
      det_s  <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      det1   <= detect_raw;
      det_s  <= det1;
      trig_q <= trig_lvl;
    end
  end

  assign trig_rise = trig_lvl & ~trig_q;
  assign arm_go    = (state == ST_IDLE) && (nxt == ST_ARM);
  assign pass      = (light_cnt >= DMIN) && (ambient_cnt <= AMAX);

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) state <= ST_IDLE;
    else              state <= nxt;
  end

  // A frame_start coinciding with the trigger edge only arms; BLACK waits a full frame.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (trig_rise && shots_left != 2'd0) nxt = ST_ARM;
      ST_ARM:   if (frame_start) nxt = ST_BLACK;
      ST_BLACK: if (frame_start) nxt = ST_WHITE;
      ST_WHITE: if (frame_start) nxt = ST_EVAL;
      ST_EVAL:  nxt = ST_HOLD;
      ST_HOLD:  if (!trig_lvl) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    flash = IDLE;
    hit   = 1'b0;
    miss  = 1'b0;
    busy  = (state != ST_IDLE);
    case (state)
      ST_BLACK: flash = BLACK;
      ST_WHITE: flash = WHITE;
      ST_EVAL:  begin hit = pass; miss = ~pass; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      ambient_cnt <= '0;
      light_cnt   <= '0;
    end else if (arm_go) begin
      ambient_cnt <= '0;
      light_cnt   <= '0;
    end else if (valid && det_s) begin
      if (state == ST_BLACK) ambient_cnt <= sat_inc(ambient_cnt);
      if (state == ST_WHITE) light_cnt   <= sat_inc(light_cnt);
    end
  end

  // new_round takes priority over the EVAL decrement
  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset)                                  shots_left <= RLOAD;
    else if (new_round)                                shots_left <= RLOAD;
    else if (state == ST_EVAL && shots_left != 2'd0)   shots_left <= shots_left - 2'd1;
  end
endmodule
